// File: rtl/echo_indication_serializer.sv
// echo_indication_serializer: buffers 96-bit indication messages and emits each as header/meth/v words.
// Messages with a zero tag are dropped at the input and only counted.
module echo_indication_serializer #(
    parameter int DEPTH     = 2,
    parameter int MSG_WORDS = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pipe_enq_ena,
    input  logic [95:0] pipe_enq_v,
    output logic        pipe_enq_rdy,
    output logic        out_enq_ena,
    output logic [31:0] out_enq_v,
    input  logic        out_enq_rdy,
    output logic [31:0] msg_count,
    output logic [15:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PONE = 1;
    localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {HDR, METH, VAL} word_e;

    logic [95:0] mem_q [DEPTH];
    logic [95:0] mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    word_e       w_q, w_d;
    logic [31:0] msg_count_q, msg_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        full, empty, push, tag_zero;
    logic [95:0] head;

    assign full         = (wr_ptr_q ^ rd_ptr_q) == FULL_DIFF;
    assign empty        = wr_ptr_q == rd_ptr_q;
    assign pipe_enq_rdy = !full;
    assign push         = pipe_enq_ena && !full;
    assign tag_zero     = pipe_enq_v[31:0] == 32'd0;
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign out_enq_ena  = !empty && out_enq_rdy;
    assign out_enq_v    = !out_enq_ena ? 32'd0 :
                          w_q == HDR    ? {head[15:0], 16'(MSG_WORDS)} :
                          w_q == METH   ? head[63:32] : head[95:64];
    assign msg_count    = msg_count_q;
    assign drop_count   = drop_count_q;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        w_d          = w_q;
        msg_count_d  = msg_count_q;
        drop_count_d = drop_count_q;
        if (push && tag_zero)
            drop_count_d = drop_count_q == 16'hFFFF ? drop_count_q : drop_count_q + 16'd1;
        if (push && !tag_zero) begin
            mem_d[wr_ptr_q[AW-1:0]] = pipe_enq_v;
            wr_ptr_d = wr_ptr_q + PONE;
        end
        // the head entry is released only once its final word has transferred
        if (out_enq_ena) begin
            w_d = w_q == HDR ? METH : w_q == METH ? VAL : HDR;
            if (w_q == VAL) begin
                rd_ptr_d    = rd_ptr_q + PONE;
                msg_count_d = msg_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            w_q          <= HDR;
            msg_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            w_q          <= w_d;
            msg_count_q  <= msg_count_d;
            drop_count_q <= drop_count_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_echo_indication_serializer.sv
// tb_echo_indication_serializer: random and directed stimulus checked against a word-queue model.
module tb_echo_indication_serializer;
    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst;
    logic        p_ena;
    logic [95:0] p_v;
    logic        p_rdy;
    logic        o_ena;
    logic [31:0] o_v;
    logic        o_rdy;
    logic [31:0] msg_count;
    logic [15:0] drop_count;

    echo_indication_serializer #(.DEPTH(DEPTH), .MSG_WORDS(3)) dut (
        .CLK(clk), .RST(rst),
        .pipe_enq_ena(p_ena), .pipe_enq_v(p_v), .pipe_enq_rdy(p_rdy),
        .out_enq_ena(o_ena), .out_enq_v(o_v), .out_enq_rdy(o_rdy),
        .msg_count(msg_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] wq[$];
    logic [31:0] m_msgs;
    logic [15:0] m_drops;
    bit          inited = 0;

    logic        s_rdy, s_ena;
    logic [31:0] s_v, s_msgs;
    logic [15:0] s_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: drive, sample, compare against model, advance model, step past the edge
    task automatic cycle(input logic r, input logic en, input logic [95:0] msg, input logic ordy);
        int occ;
        logic e_rdy, e_ena;
        logic [31:0] e_v;
        rst = r; p_ena = en; p_v = msg; o_rdy = ordy;
        #1;
        s_rdy = p_rdy; s_ena = o_ena; s_v = o_v; s_msgs = msg_count; s_drops = drop_count;
        occ   = (wq.size() + 2) / 3;
        e_rdy = occ < DEPTH;
        e_ena = wq.size() > 0 && ordy;
        e_v   = e_ena ? wq[0] : 32'd0;
        if (inited) begin
            chk("pipe_rdy", {31'd0, s_rdy}, {31'd0, e_rdy});
            chk("out_ena", {31'd0, s_ena}, {31'd0, e_ena});
            chk("out_v", s_v, e_v);
            chk("msg_count", s_msgs, m_msgs);
            chk("drop_count", {16'd0, s_drops}, {16'd0, m_drops});
        end
        if (r) begin
            wq.delete();
            m_msgs = 0;
            m_drops = 0;
            inited = 1;
        end else begin
            if (e_ena) begin
                void'(wq.pop_front());
                if (wq.size() % 3 == 0) m_msgs++;
            end
            if (en && e_rdy) begin
                if (msg[31:0] == 0) m_drops = m_drops == 16'hFFFF ? m_drops : m_drops + 1;
                else begin
                    wq.push_back({msg[15:0], 16'd3});
                    wq.push_back(msg[63:32]);
                    wq.push_back(msg[95:64]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] mk(input logic [31:0] v, input logic [31:0] m, input logic [31:0] t);
        return {v, m, t};
    endfunction

    logic [95:0] pend;
    bit          pend_v;
    logic [31:0] base;

    initial begin
        rst = 1; p_ena = 0; p_v = 0; o_rdy = 0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("reset_rdy", {31'd0, s_rdy}, 32'd1);
        chk("reset_ena", {31'd0, s_ena}, 32'd0);
        chk("reset_msgs", s_msgs, 32'd0);
        chk("reset_drops", {16'd0, s_drops}, 32'd0);

        cycle(0, 1, mk(32'hDEADBEEF, 32'h5, 32'h1), 1);
        chk("lat_idle", {31'd0, s_ena}, 32'd0);
        cycle(0, 0, 0, 1);
        chk("w_hdr", s_v, 32'h0001_0003);
        cycle(0, 0, 0, 1);
        chk("w_meth", s_v, 32'h5);
        cycle(0, 0, 0, 1);
        chk("w_val", s_v, 32'hDEADBEEF);
        cycle(0, 0, 0, 1);
        chk("one_msg", s_msgs, 32'd1);

        cycle(0, 1, mk(32'hA0, 32'hA1, 32'h3), 0);
        cycle(0, 1, mk(32'hB0, 32'hB1, 32'h4), 0);
        cycle(0, 1, mk(32'hC0, 32'hC1, 32'h5), 0);
        chk("full_rdy", {31'd0, s_rdy}, 32'd0);
        pend_v = 1;
        for (int i = 0; i < 9; i++) begin
            cycle(0, pend_v, mk(32'hC0, 32'hC1, 32'h5), 1);
            if (pend_v && s_rdy) pend_v = 0;
            chk("no_gap", {31'd0, s_ena}, 32'd1);
        end
        cycle(0, 0, 0, 1);
        chk("three_msgs", s_msgs, 32'd4);

        cycle(0, 1, mk(32'h11, 32'h12, 32'h0), 1);
        cycle(0, 1, mk(32'h21, 32'h22, 32'h2), 1);
        cycle(0, 0, 0, 1);
        chk("tag2_hdr", s_v, 32'h0002_0003);
        chk("drop_one", {16'd0, s_drops}, 32'd1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        cycle(0, 1, mk(32'h31, 32'h32, 32'h9), 1);
        cycle(0, 0, 0, 1);
        chk("pre_rst_hdr", s_v, 32'h0009_0003);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        chk("post_rst_ena", {31'd0, s_ena}, 32'd0);
        chk("post_rst_rdy", {31'd0, s_rdy}, 32'd1);
        cycle(0, 1, mk(32'h41, 32'h42, 32'h7), 1);
        cycle(0, 0, 0, 1);
        chk("restart_hdr", s_v, 32'h0007_0003);

        pend_v = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend_v && $urandom_range(0, 2) != 0) begin
                pend = {$urandom(), $urandom(), $urandom_range(0, 3) == 0 ? 32'd0 : $urandom()};
                pend_v = 1;
            end
            if ($urandom_range(0, 299) == 0) begin
                cycle(1, pend_v, pend, $urandom_range(0, 1) == 1);
                pend_v = 0;
            end else begin
                cycle(0, pend_v, pend, $urandom_range(0, 3) != 0 || i % 2 == 0);
                if (pend_v && s_rdy) pend_v = 0;
            end
        end
        base = m_msgs;
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
        chk("drained", {31'd0, s_ena}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/echo_indication_serializer.md
Name: echo_indication_serializer

Overview:
- Downstream stage of the echo indication output block. Consumes its 96-bit pipe messages, packed as {v[95:64], meth[63:32], tag[31:0]}.
- Buffers messages in a small FIFO and serializes each one into three 32-bit words on the portal word stream: header, meth, v.
- Sits between the indication output stage and the host-facing portal FIFO.

Parameters:
- DEPTH, 2, message FIFO entries; power of two, minimum 2.
- MSG_WORDS, 3, words per message including the header; fixed at 3, used in the header length field.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- pipe$enq__ENA  input  1  upstream offers a message this cycle.
- pipe$enq$v  input  96  message {v, meth, tag}.
- pipe$enq__RDY  output  1  block can accept a message.
- out$enq__ENA  output  1  a word transfers this cycle.
- out$enq$v  output  32  word being transferred.
- out$enq__RDY  input  1  downstream can take a word.
- msg_count  output  32  messages fully emitted.
- drop_count  output  16  messages discarded because tag == 0.

Behaviour:
- Reset (RST high at a CLK edge): FIFO empty, read/write pointers 0, word index 0, msg_count 0, drop_count 0.
  - Outputs after reset: pipe$enq__RDY = 1, out$enq__ENA = 0, out$enq$v = 0.
  - Reset mid-message discards the partial message and all buffered messages. No further words are emitted for them.
- Input handshake:
  - pipe$enq__RDY = !full, combinational from registered state only.
  - A push occurs when pipe$enq__ENA & pipe$enq__RDY.
  - pipe$enq__ENA while RDY is low is ignored; the upstream stage must hold the message.
- Tag filter:
  - An accepted message with tag[31:0] == 0 is not written to the FIFO.
  - drop_count increments by 1 and saturates at 16'hFFFF.
  - The handshake still completes, because RDY was high.
- FIFO:
  - DEPTH entries of 96 bits; pointer width log2(DEPTH)+1.
  - full = DEPTH entries stored; empty = none stored.
  - An entry is popped only after its third word transfers.
  - Push and final-word pop in the same cycle are both performed and occupancy is unchanged. This cannot happen when full, because RDY is low when full; there is no bypass.
  - A push into an empty FIFO is first presented on out$enq$v the next cycle (minimum latency 1 cycle).
- Word sequencer, word index w in {0,1,2} applied to the head entry:
  - w=0 HDR: out$enq$v = {tag[15:0], MSG_WORDS[15:0]}.
  - w=1 METH: out$enq$v = meth.
  - w=2 VAL: out$enq$v = v.
- Output handshake:
  - out$enq__ENA = !empty & out$enq__RDY.
  - out$enq$v = selected word when out$enq__ENA is high, else 0.
  - On each transfer, w advances (0→1→2). At w=2 the transfer pops the head, sets w to 0, and increments msg_count (wraps at 2^32).
  - out$enq__RDY low stalls: w and the FIFO hold, nothing is emitted, and the word resumes unchanged when RDY returns.
- Back-to-back messages stream with no idle cycle between the VAL word and the next HDR word.

Test Plan:
- Reset then idle → pipe$enq__RDY=1, out$enq__ENA=0, msg_count=0, drop_count=0.
- Push {v=32'hDEADBEEF, meth=32'h5, tag=1} with out$enq__RDY=1 → words 32'h0001_0003, 32'h5, 32'hDEADBEEF on 3 consecutive cycles starting 1 cycle after push; msg_count=1.
- Hold out$enq__RDY=0, push 3 messages (DEPTH=2) → first 2 accepted, then pipe$enq__RDY=0 and the third is held. Release RDY → 9 words emitted in order, no gaps; msg_count=3.
- Toggle out$enq__RDY every cycle during a message → each word is emitted exactly once and in order, and out$enq__ENA never asserts while RDY is low.
- Push a message with tag=0 followed by one with tag=2 → only the tag=2 message is emitted (header 32'h0002_0003); drop_count=1.
- Assert RST after the HDR word of a message → no METH/VAL words follow, FIFO empty, pipe$enq__RDY=1. A new message then starts cleanly at HDR.
